spy_chain_sensor: RTL and testbench

//  Parametrised delay-sensor built on a chain of STAGES inverting spy-path stages (singlepath_3_spy_p1, side inputs tied 0,0,1,0).

---
 rtl/spy_chain_sensor.sv | 268 ++++++++++++++++++++++++++
 tb/tb_spy_chain_sensor.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/spy_chain_sensor.sv
// spy_chain_sensor: on-fabric delay/voltage spy.
// A flop launches a transition into a chain of STAGES inverting spy-path cells.
// One clock later, TAPS evenly spaced tap points are captured and resynchronised.
// The captured taps are decoded into a "reach": how far the edge propagated.
// 2**LOG2_SAMPLES reaches are summed per run and held behind a valid/ack handshake.
// Optional feature macro: SPY_MINMAX_EN adds per-run reach_min/reach_max outputs.

// One inverting spy-path cell. Side inputs are tied 0,0,1,0 by the caller,
// which reduces the cell to a plain inverter on a_i.
module singlepath_3_spy_p1 (
  input  logic a_i,
  input  logic s0_i,
  input  logic s1_i,
  input  logic s2_i,
  input  logic s3_i,
  output logic y_o
);
  assign y_o = ~((a_i & s2_i) | s0_i | s1_i | s3_i);
endmodule

module spy_chain_sensor #(
  parameter  int STAGES       = 100,
  parameter  int TAPS         = 10,
  parameter  int LOG2_SAMPLES = 4,
  localparam int REACH_W      = $clog2(TAPS + 1),
  localparam int SUM_W        = REACH_W + LOG2_SAMPLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               result_valid,
  input  logic               result_ack,
  output logic [SUM_W-1:0]   reach_sum,
  output logic [REACH_W-1:0] last_reach,
  output logic               bubble_err
`ifdef SPY_MINMAX_EN
  ,
  output logic [REACH_W-1:0] reach_min,
  output logic [REACH_W-1:0] reach_max
`endif
);

  localparam int CNT_W = (LOG2_SAMPLES > 0) ? LOG2_SAMPLES : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_SAMPLES) - 1);
  localparam logic [REACH_W-1:0] REACH_FULL = REACH_W'(TAPS);

  // Parity of the number of inversions between the chain input and each tap.
  function automatic logic [TAPS-1:0] tap_parity();
    logic [TAPS-1:0] p;
    p = '0;
    for (int i = 0; i < TAPS; i++) begin
      p[i] = (((i + 1) * STAGES / TAPS) % 2) == 1;
    end
    return p;
  endfunction

  localparam logic [TAPS-1:0] TAP_PAR = tap_parity();

  // Length of the run of matching taps starting at tap 0.
  function automatic logic [REACH_W-1:0] reach_of(input logic [TAPS-1:0] m);
    logic [REACH_W-1:0] r;
    logic               gap;
    r   = '0;
    gap = 1'b0;
    for (int i = 0; i < TAPS; i++) begin
      if (!m[i]) gap = 1'b1;
      else if (!gap) r = r + REACH_W'(1);
    end
    return r;
  endfunction

  // A matching tap beyond the first mismatch means the thermometer code has a bubble.
  function automatic logic bubble_of(input logic [TAPS-1:0] m);
    logic gap;
    logic bub;
    gap = 1'b0;
    bub = 1'b0;
    for (int i = 0; i < TAPS; i++) begin
      if (!m[i]) gap = 1'b1;
      else if (gap) bub = 1'b1;
    end
    return bub;
  endfunction

  // Elaboration-time parameter sanity.
  if (STAGES % TAPS != 0) begin : g_bad_taps
    $error("spy_chain_sensor: STAGES must be a multiple of TAPS");
  end
  if (LOG2_SAMPLES < 0 || LOG2_SAMPLES > 8) begin : g_bad_samples
    $error("spy_chain_sensor: LOG2_SAMPLES must be in 0..8");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    CAPTURE = 3'd2,
    SYNC    = 3'd3,
    DECODE  = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               launch_q, launch_d;
  logic [TAPS-1:0]    tap1_q, tap1_d;
  logic [TAPS-1:0]    tap2_q, tap2_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [REACH_W-1:0] last_q, last_d;
  logic               bub_q, bub_d;
`ifdef SPY_MINMAX_EN
  logic [REACH_W-1:0] min_q, min_d;
  logic [REACH_W-1:0] max_q, max_d;
`endif

  logic [TAPS-1:0]    tap_w;
  logic [TAPS-1:0]    raw_taps;
  logic [TAPS-1:0]    match_w;
  logic [REACH_W-1:0] reach_w;
  logic               bubble_w;

  // Delay chain: each stage output is its own kept net so nothing is merged or retimed.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    (* keep = 1 *) wire stage_out;
    if (k == 0) begin : g_first
      singlepath_3_spy_p1 u_cell (
        .a_i (launch_q),
        .s0_i(1'b0),
        .s1_i(1'b0),
        .s2_i(1'b1),
        .s3_i(1'b0),
        .y_o (stage_out)
      );
    end else begin : g_rest
      singlepath_3_spy_p1 u_cell (
        .a_i (g_stage[k-1].stage_out),
        .s0_i(1'b0),
        .s1_i(1'b0),
        .s2_i(1'b1),
        .s3_i(1'b0),
        .y_o (stage_out)
      );
    end
  end

  // Tap i observes the output of stage (i+1)*STAGES/TAPS - 1.
  for (genvar i = 0; i < TAPS; i++) begin : g_tap
    assign tap_w[i] = g_stage[(i + 1) * STAGES / TAPS - 1].stage_out;
  end
  assign raw_taps = tap_w;

  // Decode: a tap matches when it shows the launched level after its inversions.
  always_comb begin
    match_w  = tap2_q ~^ ({TAPS{launch_q}} ^ TAP_PAR);
    reach_w  = reach_of(match_w);
    bubble_w = bubble_of(match_w);
  end

  // Next-state and register updates for the sequencing FSM.
  always_comb begin
    state_d  = state_q;
    launch_d = launch_q;
    tap1_d   = tap1_q;
    tap2_d   = tap2_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    last_d   = last_q;
    bub_d    = bub_q;
`ifdef SPY_MINMAX_EN
    min_d    = min_q;
    max_d    = max_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LAUNCH;
          cnt_d   = '0;
          sum_d   = '0;
          bub_d   = 1'b0;
`ifdef SPY_MINMAX_EN
          min_d   = REACH_FULL;
          max_d   = '0;
`endif
        end
      end
      LAUNCH: begin
        launch_d = ~launch_q;
        state_d  = CAPTURE;
      end
      CAPTURE: begin
        tap1_d  = raw_taps;
        state_d = SYNC;
      end
      SYNC: begin
        tap2_d  = tap1_q;
        state_d = DECODE;
      end
      DECODE: begin
        sum_d  = sum_q + SUM_W'(reach_w);
        last_d = reach_w;
        bub_d  = bub_q | bubble_w;
`ifdef SPY_MINMAX_EN
        if (reach_w < min_q) min_d = reach_w;
        if (reach_w > max_q) max_d = reach_w;
`endif
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = LAUNCH;
        end
      end
      DONE: begin
        if (result_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any run and parks the chain input low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      launch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      launch_q <= launch_d;
    end
  end

  // Capture, decode and accumulation registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tap1_q <= '0;
      tap2_q <= '0;
      cnt_q  <= '0;
      sum_q  <= '0;
      last_q <= '0;
      bub_q  <= 1'b0;
`ifdef SPY_MINMAX_EN
      min_q  <= REACH_FULL;
      max_q  <= '0;
`endif
    end else begin
      tap1_q <= tap1_d;
      tap2_q <= tap2_d;
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      last_q <= last_d;
      bub_q  <= bub_d;
`ifdef SPY_MINMAX_EN
      min_q  <= min_d;
      max_q  <= max_d;
`endif
    end
  end

  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign reach_sum    = sum_q;
  assign last_reach   = last_q;
  assign bubble_err   = bub_q;
`ifdef SPY_MINMAX_EN
  assign reach_min    = min_q;
  assign reach_max    = max_q;
`endif

endmodule

// File: tb/tb_spy_chain_sensor.sv
// Bench for spy_chain_sensor: randomized runs checked against a sample-level model.
// Tap patterns are imposed on the raw tap bus to produce chosen match vectors.
module tb_spy_chain_sensor;

  localparam int STAGES       = 100;
  localparam int TAPS         = 10;
  localparam int LOG2_SAMPLES = 4;
  localparam int NSAMP        = 1 << LOG2_SAMPLES;
  localparam int REACH_W      = $clog2(TAPS + 1);
  localparam int SUM_W        = REACH_W + LOG2_SAMPLES;

  logic               clk;
  logic               rst;
  logic               start;
  logic               busy;
  logic               result_valid;
  logic               result_ack;
  logic [SUM_W-1:0]   reach_sum;
  logic [REACH_W-1:0] last_reach;
  logic               bubble_err;
`ifdef SPY_MINMAX_EN
  logic [REACH_W-1:0] reach_min;
  logic [REACH_W-1:0] reach_max;
`endif

  spy_chain_sensor #(
    .STAGES      (STAGES),
    .TAPS        (TAPS),
    .LOG2_SAMPLES(LOG2_SAMPLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .result_valid(result_valid),
    .result_ack  (result_ack),
    .reach_sum   (reach_sum),
    .last_reach  (last_reach),
    .bubble_err  (bubble_err)
`ifdef SPY_MINMAX_EN
    ,
    .reach_min   (reach_min),
    .reach_max   (reach_max)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic            lq;            // model of the launch flop level
  logic [TAPS-1:0] force_v;
  logic [TAPS-1:0] pat [NSAMP];   // match vector per sample of the next run

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_reach(input logic [TAPS-1:0] m);
    int r = 0;
    while (r < TAPS && m[r]) r++;
    return r;
  endfunction

  function automatic bit model_bubble(input logic [TAPS-1:0] m);
    int r = model_reach(m);
    return (r < TAPS) && ((m >> r) != '0);
  endfunction

  // Tap levels that produce match vector m when the launched level is pol.
  function automatic logic [TAPS-1:0] taps_for(input logic [TAPS-1:0] m, input logic pol);
    logic [TAPS-1:0] t;
    int              inv;
    logic            ideal;
    t = '0;
    for (int i = 0; i < TAPS; i++) begin
      inv   = (i + 1) * STAGES / TAPS;
      ideal = pol ^ inv[0];
      t[i]  = m[i] ? ideal : ~ideal;
    end
    return t;
  endfunction

  function automatic logic [TAPS-1:0] thermo(input int r);
    return TAPS'((1 << r) - 1);
  endfunction

  task automatic run(input bit use_force, input int ack_wait, input bit noisy, input string tag);
    int exp_sum  = 0;
    int exp_last = 0;
    int exp_min  = TAPS;
    int exp_max  = 0;
    bit exp_bub  = 0;
    bit early    = 0;
    int r;
    for (int s = 0; s < NSAMP; s++) begin
      r = model_reach(pat[s]);
      exp_sum += r;
      exp_last = r;
      if (r < exp_min) exp_min = r;
      if (r > exp_max) exp_max = r;
      if (model_bubble(pat[s])) exp_bub = 1;
    end
    release dut.raw_taps;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int s = 0; s < NSAMP; s++) begin
      @(posedge clk); #1;
      lq = ~lq;
      if (use_force) begin
        force_v = taps_for(pat[s], lq);
        force dut.raw_taps = force_v;
      end
      if (noisy) start = 1'($urandom_range(0, 1));
      result_ack = (s < NSAMP - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      for (int c = 0; c < 3; c++) begin
        if (result_valid) early = 1;
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    chk({tag, " early_valid"}, 32'(early), 32'd0);
    chk({tag, " valid_at_latency"}, 32'(result_valid), 32'd1);
    chk({tag, " reach_sum"}, 32'(reach_sum), 32'(exp_sum));
    chk({tag, " last_reach"}, 32'(last_reach), 32'(exp_last));
    chk({tag, " bubble_err"}, 32'(bubble_err), 32'(exp_bub));
`ifdef SPY_MINMAX_EN
    chk({tag, " reach_min"}, 32'(reach_min), 32'(exp_min));
    chk({tag, " reach_max"}, 32'(reach_max), 32'(exp_max));
`endif
    for (int w = 0; w < ack_wait; w++) begin
      start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      chk({tag, " hold_valid"}, 32'(result_valid), 32'd1);
      chk({tag, " hold_sum"}, 32'(reach_sum), 32'(exp_sum));
    end
    result_ack = 1'b1;
    start      = noisy;
    @(posedge clk); #1;
    result_ack = 1'b0;
    start      = 1'b0;
    chk({tag, " valid_after_ack"}, 32'(result_valid), 32'd0);
    chk({tag, " busy_after_ack"}, 32'(busy), 32'd0);
    chk({tag, " sum_kept_idle"}, 32'(reach_sum), 32'(exp_sum));
    @(posedge clk); #1;
    chk({tag, " stay_idle"}, 32'(busy), 32'd0);
    release dut.raw_taps;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    result_ack = 1'b0;
    lq         = 1'b0;
    force_v    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst valid", 32'(result_valid), 32'd0);
    chk("rst sum", 32'(reach_sum), 32'd0);
    chk("rst last", 32'(last_reach), 32'd0);
    chk("rst bubble", 32'(bubble_err), 32'd0);
    rst = 1'b0;

    // Abort a run part-way with a three-cycle reset.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("midrun busy", 32'(busy), 32'd1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort valid", 32'(result_valid), 32'd0);
    chk("abort sum", 32'(reach_sum), 32'd0);
    chk("abort bubble", 32'(bubble_err), 32'd0);
    rst = 1'b0;
    lq  = 1'b0;

    // Unforced chain: edge reaches every tap.
    for (int s = 0; s < NSAMP; s++) pat[s] = thermo(TAPS);
    run(1'b0, 1, 1'b0, "clean");

    // Taps 0..5 match, 6..9 miss.
    for (int s = 0; s < NSAMP; s++) pat[s] = thermo(6);
    run(1'b1, 2, 1'b0, "reach6");

    // Bubble pattern 1,1,0,1,... then a clean run clears the sticky flag.
    for (int s = 0; s < NSAMP; s++) pat[s] = TAPS'(10'b1111111011);
    run(1'b1, 1, 1'b0, "bubble");
    for (int s = 0; s < NSAMP; s++) pat[s] = thermo(TAPS);
    run(1'b0, 1, 1'b0, "clean2");

    // Long ack hold with start noise during the run and in DONE.
    for (int s = 0; s < NSAMP; s++) pat[s] = thermo(int'($urandom_range(0, TAPS)));
    run(1'b1, 20, 1'b1, "handshake");

    // Alternating reaches 3 and 8.
    for (int s = 0; s < NSAMP; s++) pat[s] = (s % 2 == 0) ? thermo(3) : thermo(8);
    run(1'b1, 1, 1'b0, "alt38");

    // Randomized runs: thermometer codes (incl. 0 and TAPS) and arbitrary bit patterns.
    for (int n = 0; n < 8; n++) begin
      for (int s = 0; s < NSAMP; s++) begin
        if ($urandom_range(0, 1) == 0) pat[s] = thermo(int'($urandom_range(0, TAPS)));
        else pat[s] = TAPS'($urandom);
      end
      run(1'b1, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
